// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, colours and arbiter state encoding
package vga_pkg;

    localparam int WIDTH    = 160;
    localparam int HEIGHT   = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - pixel producer bus into the framebuffer write arbiter
interface fb_write_arbiter_if
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          lock;
    logic [NUM_REQ*X_W-1:0]      x_in;
    logic [NUM_REQ*Y_W-1:0]      y_in;
    logic [NUM_REQ*COLOUR_W-1:0] colour_in;
    logic [NUM_REQ-1:0]          grant;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic [COLOUR_W-1:0]         colour;
    logic                        plot;
    logic                        busy;
    logic                        err_oob;

    modport master (
        output req, lock, x_in, y_in, colour_in,
        input  grant, x, y, colour, plot, busy, err_oob
    );

    modport slave (
        input  req, lock, x_in, y_in, colour_in,
        output grant, x, y, colour, plot, busy, err_oob
    );

endinterface

// File: rtl/fb_write_arbiter_rr_picker.sv
// rtl/fb_write_arbiter_rr_picker.sv - round-robin picker: first request after ptr, wrapping
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // ptr itself is scanned last, so the previous winner has lowest priority
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin framebuffer write arbiter with atomic fill lock
module fb_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic              clk,
    input logic              rst,
    fb_write_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [X_W:0] X_LIM = (X_W+1)'(WIDTH);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(HEIGHT);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   sel;
    logic               xfer;
    logic               in_bounds;
    logic [X_W-1:0]     x_sel;
    logic [Y_W-1:0]     y_sel;
    logic [COLOUR_W-1:0] colour_sel;

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;
    logic                err_q;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Grant is withheld during reset so no producer advances past a pixel that is dropped
    always_comb begin
        grant_c    = '0;
        sel        = pick_idx;
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        if (!rst) begin
            case (state)
                ST_IDLE:   grant_c = pick_grant;
                ST_LOCKED: begin
                    sel = owner;
                    if (bus.req[owner]) grant_c[owner] = 1'b1;
                end
                default:   grant_c = '0;
            endcase
        end
        xfer = |grant_c;
        if (xfer) begin
            rr_ptr_nxt = sel;
            if (state == ST_IDLE && bus.lock[sel]) begin
                state_nxt = ST_LOCKED;
                owner_nxt = sel;
            end else if (state == ST_LOCKED && !bus.lock[sel]) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    assign x_sel      = bus.x_in[sel*X_W +: X_W];
    assign y_sel      = bus.y_in[sel*Y_W +: Y_W];
    assign colour_sel = bus.colour_in[sel*COLOUR_W +: COLOUR_W];
    assign in_bounds  = ({1'b0, x_sel} < X_LIM) && ({1'b0, y_sel} < Y_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            plot_q <= xfer && in_bounds;
            if (xfer && in_bounds) begin
                x_q      <= x_sel;
                y_q      <= y_sel;
                colour_q <= colour_sel;
            end
            if (xfer && !in_bounds) err_q <= 1'b1;
        end
    end

    assign bus.grant   = grant_c;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.colour  = colour_q;
    assign bus.plot    = plot_q;
    assign bus.busy    = (state == ST_LOCKED);
    assign bus.err_oob = err_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed vector bench for fb_write_arbiter
module tb_fb_write_arbiter;
    import vga_pkg::*;

    localparam int NR = 4;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] lock;
        logic [NR-1:0] grant;
        logic          plot;
        logic          busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_write_arbiter_if #(.NUM_REQ(NR)) bus ();

    fb_write_arbiter #(.NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [X_W-1:0]      px [NR];
    logic [Y_W-1:0]      py [NR];
    logic [COLOUR_W-1:0] pc [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic [NR-1:0] r, input logic [NR-1:0] l);
        bus.req  = r;
        bus.lock = l;
        for (int i = 0; i < NR; i++) begin
            bus.x_in[i*X_W +: X_W]                = px[i];
            bus.y_in[i*Y_W +: Y_W]                = py[i];
            bus.colour_in[i*COLOUR_W +: COLOUR_W] = pc[i];
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [22];

    initial begin
        int prev_idx;
        int errs;
        int plots;
        logic [X_W-1:0] ex;
        logic [Y_W-1:0] ey;

        px[0] = 8'd5;   py[0] = 7'd7;   pc[0] = WHITE;
        px[1] = 8'd30;  py[1] = 7'd20;  pc[1] = RED;
        px[2] = 8'd60;  py[2] = 7'd40;  pc[2] = GREEN;
        px[3] = 8'd159; py[3] = 7'd119; pc[3] = 3'b001;

        vecs = '{
            '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0},
            '{4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0},
            '{4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0},
            '{4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0},
            '{4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0},
            '{4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0},
            '{4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0},
            '{4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0},
            '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0},
            '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0},
            '{4'b0101, 4'b0001, 4'b0001, 1'b0, 1'b0},
            '{4'b0101, 4'b0001, 4'b0001, 1'b1, 1'b1},
            '{4'b0100, 4'b0001, 4'b0000, 1'b1, 1'b1},
            '{4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b1},
            '{4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b1},
            '{4'b0101, 4'b0000, 4'b0001, 1'b0, 1'b1},
            '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0},
            '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0},
            '{4'b1010, 4'b1000, 4'b1000, 1'b0, 1'b0},
            '{4'b1010, 4'b0000, 4'b1000, 1'b1, 1'b1},
            '{4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b0},
            '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0}
        };

        apply('0, '0);
        tick;
        tick;
        check("reset_plot",    32'(bus.plot),    32'd0);
        check("reset_x",       32'(bus.x),       32'd0);
        check("reset_y",       32'(bus.y),       32'd0);
        check("reset_colour",  32'(bus.colour),  32'd0);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_err_oob", 32'(bus.err_oob), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_grant", 32'(bus.grant), 32'd0);

        // Round robin, hold-off while locked, single-pixel lock
        prev_idx = -1;
        for (int r = 0; r < 22; r++) begin
            check($sformatf("v%0d_plot", r), 32'(bus.plot), 32'(vecs[r].plot));
            check($sformatf("v%0d_busy", r), 32'(bus.busy), 32'(vecs[r].busy));
            check($sformatf("v%0d_err", r),  32'(bus.err_oob), 32'd0);
            if (vecs[r].plot && prev_idx >= 0) begin
                check($sformatf("v%0d_x", r),      32'(bus.x),      32'(px[prev_idx]));
                check($sformatf("v%0d_y", r),      32'(bus.y),      32'(py[prev_idx]));
                check($sformatf("v%0d_colour", r), 32'(bus.colour), 32'(pc[prev_idx]));
            end
            apply(vecs[r].req, vecs[r].lock);
            #1;
            check($sformatf("v%0d_grant", r), 32'(bus.grant), 32'(vecs[r].grant));
            prev_idx = -1;
            for (int i = 0; i < NR; i++) if (vecs[r].grant[i]) prev_idx = i;
            tick;
        end

        // Locked full-screen fill by requester 0 against a pending requester 1
        errs  = 0;
        plots = 0;
        ex    = '0;
        ey    = '0;
        for (int p = 0; p < WIDTH*HEIGHT; p++) begin
            if (p > 0) begin
                if (bus.plot === 1'b1) plots++;
                if (bus.x !== ex || bus.y !== ey || bus.colour !== BLACK) errs++;
                if (bus.busy !== 1'b1) errs++;
            end
            px[0] = X_W'(p % WIDTH);
            py[0] = Y_W'(p / WIDTH);
            pc[0] = BLACK;
            ex    = px[0];
            ey    = py[0];
            apply(4'b0011, {3'b000, (p != WIDTH*HEIGHT-1)});
            #1;
            if (bus.grant !== 4'b0001) errs++;
            tick;
        end
        if (bus.plot === 1'b1) plots++;
        check("fill_errors",  32'(errs),   32'd0);
        check("fill_plots",   32'(plots),  32'(WIDTH*HEIGHT));
        check("fill_last_x",  32'(bus.x),  32'd159);
        check("fill_last_y",  32'(bus.y),  32'd119);
        check("fill_busy_end", 32'(bus.busy), 32'd0);
        apply(4'b0010, 4'b0000);
        #1;
        check("after_fill_grant", 32'(bus.grant), 32'b0010);
        tick;
        check("after_fill_plot", 32'(bus.plot), 32'd1);
        check("after_fill_x",    32'(bus.x),    32'd30);

        // Out-of-bounds pixels are consumed without a plot; the error is sticky
        px[1] = 8'd160;
        py[1] = 7'd0;
        apply(4'b0010, 4'b0000);
        #1;
        check("oob_x_grant", 32'(bus.grant), 32'b0010);
        tick;
        check("oob_x_plot", 32'(bus.plot),    32'd0);
        check("oob_x_err",  32'(bus.err_oob), 32'd1);
        check("oob_x_hold", 32'(bus.x),       32'd30);
        px[1] = 8'd10;
        py[1] = 7'd119;
        apply(4'b0010, 4'b0000);
        tick;
        check("oob_valid_plot", 32'(bus.plot),    32'd1);
        check("oob_valid_x",    32'(bus.x),       32'd10);
        check("oob_valid_err",  32'(bus.err_oob), 32'd1);
        px[1] = 8'd0;
        py[1] = 7'd120;
        apply(4'b0010, 4'b0000);
        #1;
        check("oob_y_grant", 32'(bus.grant), 32'b0010);
        tick;
        check("oob_y_plot", 32'(bus.plot), 32'd0);
        apply(4'b0000, 4'b0000);
        tick;
        check("oob_sticky", 32'(bus.err_oob), 32'd1);

        // Reset in the middle of a locked burst
        apply(4'b0001, 4'b0001);
        #1;
        check("lock_grant", 32'(bus.grant), 32'b0001);
        tick;
        check("lock_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        tick;
        check("rst_plot", 32'(bus.plot),    32'd0);
        check("rst_busy", 32'(bus.busy),    32'd0);
        check("rst_err",  32'(bus.err_oob), 32'd0);
        check("rst_x",    32'(bus.x),       32'd0);
        rst = 1'b0;
        apply(4'b1000, 4'b0000);
        #1;
        check("post_rst_grant", 32'(bus.grant), 32'b1000);
        tick;
        check("post_rst_plot",   32'(bus.plot),   32'd1);
        check("post_rst_x",      32'(bus.x),      32'd159);
        check("post_rst_colour", 32'(bus.colour), 32'b001);
        apply('0, '0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
